// File: rtl/flag_branch_unit_if.sv
// Flag/branch bundle between EX, decode and fetch.
// The unit itself uses the slave modport.
interface flag_branch_unit_if #(
  parameter int PC_W = 16
);
  logic            ex_valid;
  logic [3:0]      ex_opcode;
  logic            z_set;
  logic            v_set;
  logic            n_set;
  logic            br_valid;
  logic            br_is_reg;
  logic [2:0]      br_cond;
  logic [8:0]      br_imm;
  logic [PC_W-1:0] br_reg;
  logic [PC_W-1:0] pc_plus2;
  logic            flush;
  logic [2:0]      flags;
  logic            hold;
  logic            br_done;
  logic            br_taken;
  logic [PC_W-1:0] br_target;

  modport master (
    output ex_valid, ex_opcode,
    output z_set, v_set, n_set,
    output br_valid, br_is_reg, br_cond,
    output br_imm, br_reg, pc_plus2, flush,
    input  flags, hold,
    input  br_done, br_taken, br_target
  );

  modport slave (
    input  ex_valid, ex_opcode,
    input  z_set, v_set, n_set,
    input  br_valid, br_is_reg, br_cond,
    input  br_imm, br_reg, pc_plus2, flush,
    output flags, hold,
    output br_done, br_taken, br_target
  );
endinterface

// File: rtl/flag_branch_unit.sv
// Z/V/N flag register and conditional branch resolver.
// Optional macro BR_STATS_EN adds resolved/taken counters.
module flag_branch_unit #(
  parameter bit BYPASS = 1'b1,
  parameter int PC_W   = 16
) (
  input  logic clk,
  input  logic rst,
  flag_branch_unit_if.slave bus
`ifdef BR_STATS_EN
  ,
  output logic [15:0] stat_resolved,
  output logic [15:0] stat_taken
`endif
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [2:0]      flags_q;
  logic [2:0]      eff_flags;
  logic            wr_all;
  logic            wr_z;
  logic            hazard;
  logic [PC_W-1:0] imm_ext;
  logic [PC_W-1:0] b_tgt;
  logic [PC_W-1:0] br_tgt;
  logic [2:0]      pend_cond;
  logic [PC_W-1:0] pend_tgt;
  logic            hold_c;
  logic            cap;
  logic            res_en;
  logic            res_taken;
  logic [PC_W-1:0] res_tgt;
  logic            done_q;
  logic            taken_q;
  logic [PC_W-1:0] target_q;

  function automatic logic cond_ok(
    input logic [2:0] c,
    input logic [2:0] f
  );
    logic z;
    logic v;
    logic n;
    logic r;
    z = f[2];
    v = f[1];
    n = f[0];
    r = 1'b0;
    unique case (c)
      3'b000: r = !z;
      3'b001: r = z;
      3'b010: r = !z && !n;
      3'b011: r = n;
      3'b100: r = z || (!z && !n);
      3'b101: r = n || z;
      3'b110: r = v;
      3'b111: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // opcode class decode for flag writers
  always_comb begin
    wr_all = 1'b0;
    wr_z   = 1'b0;
    unique case (1'b1)
      (bus.ex_opcode inside {4'h0, 4'h1}):
        wr_all = 1'b1;
      (bus.ex_opcode inside {4'h2, 4'h4, 4'h5, 4'h6}):
        wr_z = 1'b1;
      default: ;
    endcase
  end

  // flags as they stand after this edge's update
  always_comb begin
    eff_flags = flags_q;
    if (bus.ex_valid && wr_all) begin
      eff_flags = {bus.z_set, bus.v_set, bus.n_set};
    end else if (bus.ex_valid && wr_z) begin
      eff_flags[2] = bus.z_set;
    end
  end

  assign hazard  = bus.br_valid && bus.ex_valid && (wr_all || wr_z);
  assign imm_ext = PC_W'($signed(bus.br_imm));
  assign b_tgt   = bus.pc_plus2 + (imm_ext << 1);
  assign br_tgt  = bus.br_is_reg ? bus.br_reg : b_tgt;

  // next state, hazard hold and resolution select
  always_comb begin
    state_d   = state_q;
    hold_c    = 1'b0;
    cap       = 1'b0;
    res_en    = 1'b0;
    res_taken = 1'b0;
    res_tgt   = br_tgt;
    unique case (state_q)
      IDLE: begin
        if (bus.br_valid && !bus.flush) begin
          if (hazard && !BYPASS) begin
            hold_c  = 1'b1;
            cap     = 1'b1;
            state_d = HOLD;
          end else begin
            res_en    = 1'b1;
            res_taken = cond_ok(bus.br_cond,
                                BYPASS ? eff_flags : flags_q);
          end
        end
      end
      HOLD: begin
        state_d = IDLE;
        if (!bus.flush) begin
          res_en    = 1'b1;
          res_taken = cond_ok(pend_cond, flags_q);
          res_tgt   = pend_tgt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // architectural flags, never blocked by flush
  always_ff @(posedge clk) begin
    if (rst) flags_q <= 3'b000;
    else     flags_q <= eff_flags;
  end

  // pending branch captured on a hazard hold
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_cond <= 3'b000;
      pend_tgt  <= '0;
    end else if (cap) begin
      pend_cond <= bus.br_cond;
      pend_tgt  <= br_tgt;
    end
  end

  // registered result to fetch; taken/target sticky
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q   <= 1'b0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      done_q <= res_en;
      if (res_en) begin
        taken_q  <= res_taken;
        target_q <= res_tgt;
      end
    end
  end

`ifdef BR_STATS_EN
  // saturating counters, bumped as the result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved <= 16'h0000;
      stat_taken    <= 16'h0000;
    end else if (res_en) begin
      if (stat_resolved != 16'hFFFF)
        stat_resolved <= stat_resolved + 16'h0001;
      if (res_taken && stat_taken != 16'hFFFF)
        stat_taken <= stat_taken + 16'h0001;
    end
  end
`endif

  assign bus.flags     = flags_q;
  assign bus.hold      = hold_c && !rst;
  assign bus.br_done   = done_q;
  assign bus.br_taken  = taken_q;
  assign bus.br_target = target_q;

endmodule
